ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single data-RAM port (wr_sig / wr_data / addr / rd_data) between two bus masters.
  - Master 0: CPU load/store port.
  - Master 1: debug/program loader.
- Each transaction uses a req/ack handshake. Payload is latched at grant. Reads are sequenced to match the RAM's fixed read latency.
- Sits between cpu/loader and ram in the platform top level. It replaces the direct cpu-to-ram wiring.

Parameters:
- ADDR_W, 32, width of master and RAM addresses
- DATA_W, 32, width of read/write data
- RD_LATENCY, 1, cycles from ram_addr first driven to ram_rd_data valid (legal range 1..7)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- m0_req  input  1  master 0 request; hold high with payload stable until m0_ack
- m0_we  input  1  master 0 write (1) / read (0)
- m0_addr  input  ADDR_W  master 0 address
- m0_wdata  input  DATA_W  master 0 write data
- m0_rdata  output  DATA_W  master 0 read data; valid while m0_ack=1
- m0_ack  output  1  one-cycle completion pulse to master 0
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack  same directions, widths and meanings for master 1
- ram_wr_sig  output  1  RAM write strobe
- ram_addr  output  ADDR_W  RAM address
- ram_wr_data  output  DATA_W  RAM write data
- ram_rd_data  input  DATA_W  RAM read data
- busy  output  1  high in every state except IDLE
- grant_id  output  1  owner of the current or last transaction

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high.
- Reset:
  - state=IDLE, priority pointer=0.
  - All outputs are 0: ram_wr_sig, ram_addr, ram_wr_data, m*_ack, m*_rdata, busy, grant_id.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, arbitrate (see Optional Feature).
  - Latch winner id, we, addr, wdata into internal registers.
  - Load wait counter: 0 for a write, RD_LATENCY for a read.
  - Next state ACCESS.
- ACCESS:
  - ram_addr and ram_wr_data are driven from the latched registers.
  - ram_wr_sig = latched we. A write lasts exactly 1 cycle, so there is exactly one write strobe.
  - The counter decrements each cycle.
  - When the counter = 0 on a read, the next edge captures ram_rd_data into the winner's rdata register. Next state RESP.
  - A read lasts RD_LATENCY+1 ACCESS cycles. A write goes to RESP after its single cycle.
- RESP:
  - Winner's ack=1 for exactly one cycle. Next state IDLE.
  - rdata holds its value until the next read completes for that master. After a write, rdata is unchanged.
- RAM outputs outside ACCESS: ram_wr_sig=0, ram_addr=0, ram_wr_data=0.
- Handshake:
  - The master deasserts req on the edge that ends its ack cycle.
  - Any req high in IDLE is treated as a new transaction.
  - The loser's req stays pending, unacknowledged, and is served at the next IDLE.
- Latency:
  - Write: req seen in IDLE at cycle t, ram_wr_sig at t+1, ack at t+2.
  - Read: ack at t+RD_LATENCY+2.
- Back-to-back: minimum gap between transactions is one IDLE cycle.
- Payload changes while a transaction is in flight are ignored, because the payload is latched at grant.
- grant_id updates at grant and holds through IDLE.
- Reset asserted in ACCESS or RESP:
  - Abort; state=IDLE next cycle.
  - No ack is issued and no further ram_wr_sig.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN
- Defined: round-robin arbitration.
  - On simultaneous requests, the master that did not win last grant wins.
  - The pointer toggles to the other master after each grant.
  - A lone requester always wins and still updates the pointer.
- Undefined: fixed priority; m0 always wins simultaneous requests. The pointer register is not implemented.

Test Plan:
- Write then read, RD_LATENCY=1: m0 writes 0xDEADBEEF to 0x10, then reads 0x10 -> ram_wr_sig high exactly one cycle at t+1; write ack at t+2; read ack at t+3 with m0_rdata=0xDEADBEEF.
- Contention, fixed priority: m0 and m1 both request in the same IDLE cycle -> m0 is acked first; m1 is acked on its own next transaction. With continuous m0 requests, m1 never wins.
- Contention, round robin (ARB_ROUND_ROBIN_EN): both request continuously for 4 transactions -> grant_id sequence 0,1,0,1 (from reset pointer).
- Latency sweep: RD_LATENCY=3, m1 reads 0x20 holding 0x00000037 -> m1_ack at t+5 with m1_rdata=55; busy high from t+1 to t+5.
- Payload stability: m0 starts a write of 0x1 to 0x4, then m0_addr changes to 0x8 during ACCESS -> RAM is written at 0x4 only.
- Reset mid-read: reset asserted in the second ACCESS cycle (RD_LATENCY=3) -> IDLE next cycle; no ack; all outputs 0; a following request completes normally.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one data-RAM port between two req/ack masters
// (m0 = CPU load/store, m1 = debug/program loader).
// Ports: clk, reset (synchronous, active-high);
//   m0_req/m0_we/m0_addr/m0_wdata in, m0_rdata/m0_ack out (m1_* same);
//   ram_wr_sig/ram_addr/ram_wr_data out, ram_rd_data in;
//   busy (not IDLE), grant_id (owner of current/last transaction).
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration;
// when it is undefined, m0 has fixed priority.
module ram_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic              ram_wr_sig,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              busy,
    output logic              grant_id
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [2:0] LAT_CNT = 3'(RD_LATENCY);

    state_t            state_q;
    logic              id_q;
    logic              we_q;
    logic [2:0]        cnt_q;
    logic              ram_wr_sig_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wr_data_q;
    logic              m0_ack_q;
    logic              m1_ack_q;
    logic [DATA_W-1:0] m0_rdata_q;
    logic [DATA_W-1:0] m1_rdata_q;
    logic              busy_q;
    logic              grant_id_q;
`ifdef ARB_ROUND_ROBIN_EN
    // Points at the master preferred on the next simultaneous request.
    logic              ptr_q;
`endif

    logic              win_d;
    logic              sel_we_d;
    logic [ADDR_W-1:0] sel_addr_d;
    logic [DATA_W-1:0] sel_wdata_d;

    // A lone requester always wins; only a tie consults the policy.
    always_comb begin
        win_d = ~m0_req;
`ifdef ARB_ROUND_ROBIN_EN
        if (m0_req && m1_req) begin
            win_d = ptr_q;
        end
`endif
        sel_we_d    = win_d ? m1_we    : m0_we;
        sel_addr_d  = win_d ? m1_addr  : m0_addr;
        sel_wdata_d = win_d ? m1_wdata : m0_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            id_q          <= 1'b0;
            we_q          <= 1'b0;
            cnt_q         <= 3'd0;
            ram_wr_sig_q  <= 1'b0;
            ram_addr_q    <= '0;
            ram_wr_data_q <= '0;
            m0_ack_q      <= 1'b0;
            m1_ack_q      <= 1'b0;
            m0_rdata_q    <= '0;
            m1_rdata_q    <= '0;
            busy_q        <= 1'b0;
            grant_id_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q         <= 1'b0;
`endif
        end else begin
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        state_q       <= ACCESS;
                        busy_q        <= 1'b1;
                        id_q          <= win_d;
                        grant_id_q    <= win_d;
                        we_q          <= sel_we_d;
                        // RAM port registers double as the payload latch.
                        ram_wr_sig_q  <= sel_we_d;
                        ram_addr_q    <= sel_addr_d;
                        ram_wr_data_q <= sel_wdata_d;
                        cnt_q         <= sel_we_d ? 3'd0 : LAT_CNT;
`ifdef ARB_ROUND_ROBIN_EN
                        ptr_q         <= ~win_d;
`endif
                    end
                end
                ACCESS: begin
                    if (cnt_q == 3'd0) begin
                        state_q       <= RESP;
                        ram_wr_sig_q  <= 1'b0;
                        ram_addr_q    <= '0;
                        ram_wr_data_q <= '0;
                        if (id_q) begin
                            m1_ack_q <= 1'b1;
                        end else begin
                            m0_ack_q <= 1'b1;
                        end
                        if (!we_q) begin
                            if (id_q) begin
                                m1_rdata_q <= ram_rd_data;
                            end else begin
                                m0_rdata_q <= ram_rd_data;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ram_wr_sig  = ram_wr_sig_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wr_data = ram_wr_data_q;
    assign m0_ack      = m0_ack_q;
    assign m1_ack      = m1_ack_q;
    assign m0_rdata    = m0_rdata_q;
    assign m1_rdata    = m1_rdata_q;
    assign busy        = busy_q;
    assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized self-checking bench for ram_arbiter
// with a behavioural RAM and a transaction-level reference model.
module tb_ram_arbiter;

    localparam int LAT = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req;
    logic [1:0]       we;
    logic [1:0][31:0] addr;
    logic [1:0][31:0] wdata;
    logic [31:0]      m0_rdata;
    logic [31:0]      m1_rdata;
    logic             m0_ack;
    logic             m1_ack;
    logic             ram_wr_sig;
    logic [31:0]      ram_addr;
    logic [31:0]      ram_wr_data;
    logic [31:0]      ram_rd_data;
    logic             busy;
    logic             grant_id;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] mem [256] = '{default: '0};
    logic [31:0] pipe [LAT] = '{default: '0};
    logic [31:0] ref_mem [256] = '{default: '0};
    logic [31:0] ref_rd [2] = '{default: '0};
    logic        ref_ptr = 1'b0;

    always #5 clk = ~clk;

    ram_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .RD_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .m0_req(req[0]),
        .m0_we(we[0]),
        .m0_addr(addr[0]),
        .m0_wdata(wdata[0]),
        .m0_rdata(m0_rdata),
        .m0_ack(m0_ack),
        .m1_req(req[1]),
        .m1_we(we[1]),
        .m1_addr(addr[1]),
        .m1_wdata(wdata[1]),
        .m1_rdata(m1_rdata),
        .m1_ack(m1_ack),
        .ram_wr_sig(ram_wr_sig),
        .ram_addr(ram_addr),
        .ram_wr_data(ram_wr_data),
        .ram_rd_data(ram_rd_data),
        .busy(busy),
        .grant_id(grant_id)
    );

    // RAM with LAT cycles from address to data.
    always @(posedge clk) begin
        if (ram_wr_sig) mem[ram_addr[7:0]] <= ram_wr_data;
        pipe[0] <= mem[ram_addr[7:0]];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_rd_data = pipe[LAT-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rd_of(input int m);
        return (m != 0) ? m1_rdata : m0_rdata;
    endfunction

    function automatic logic ack_of(input int m);
        return (m != 0) ? m1_ack : m0_ack;
    endfunction

    // Reference arbitration given the set of pending requesters.
    function automatic logic arb(input logic [1:0] r);
`ifdef ARB_ROUND_ROBIN_EN
        if (r == 2'b11) return ref_ptr;
`endif
        return r[0] ? 1'b0 : 1'b1;
    endfunction

    // Runs one lone-master transaction starting in an IDLE cycle and
    // returns what was observed; ends in the following IDLE cycle.
    task automatic run_single(input int m, input logic w,
                              input logic [31:0] a, input logic [31:0] d,
                              input bit perturb,
                              output int lat, output int wrc,
                              output int accc, output int bc,
                              output logic [31:0] wd);
        lat = -1; wrc = 0; accc = 0; bc = 0; wd = '0;
        req[m] = 1'b1; we[m] = w; addr[m] = a; wdata[m] = d;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (perturb && k == 1) begin
                addr[m] = a ^ 32'h0C;
                wdata[m] = ~d;
            end
            if (busy) bc++;
            if (ram_addr === a) accc++;
            if (ram_wr_sig) begin
                wrc++;
                wd = ram_wr_data;
            end
            if (ack_of(m)) begin
                lat = k;
                break;
            end
        end
        req[m] = 1'b0;
        tick();
        ref_ptr = (m == 0);
        if (w) ref_mem[a[7:0]] = d;
        else ref_rd[m] = ref_mem[a[7:0]];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = 2'b11; we = 2'b11;
        addr[0] = $urandom; addr[1] = $urandom;
        wdata[0] = $urandom; wdata[1] = $urandom;
        tick();
        tick();
        n_cmp++;
        if ({busy, grant_id, m0_ack, m1_ack} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_status: got %b want 0000",
                     {busy, grant_id, m0_ack, m1_ack});
        end
        n_cmp++;
        if ({m0_rdata, m1_rdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h want 0", {m0_rdata, m1_rdata});
        end
        n_cmp++;
        if ({ram_wr_sig, ram_addr, ram_wr_data} !== 65'h0) begin
            n_fail++;
            $display("FAIL reset_ram: got %b %h %h want 0 0 0",
                     ram_wr_sig, ram_addr, ram_wr_data);
        end
        reset = 1'b0;
        req = 2'b00;
        ref_ptr = 1'b0;
        ref_rd = '{default: '0};
        tick();
    endtask

    task automatic test_back_to_back();
        int          rem [2];
        int          idx [2];
        logic        pw [2][4];
        logic [31:0] pa [2][4];
        logic [31:0] pd [2][4];
        logic        exp_w;
        int          got;
        int          i;
        bit          done;
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 4; k++) begin
                pw[m][k] = 1'($urandom_range(0, 1));
                pa[m][k] = 32'h80 + 32'($urandom_range(0, 7) * 4);
                pd[m][k] = $urandom;
            end
            rem[m] = 4;
            idx[m] = 0;
            req[m] = 1'b1; we[m] = pw[m][0];
            addr[m] = pa[m][0]; wdata[m] = pd[m][0];
        end
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            tick();
            if (m0_ack || m1_ack) begin
                got = m1_ack ? 1 : 0;
                exp_w = arb({rem[1] > 0, rem[0] > 0});
                n_cmp++;
                if ({m0_ack, m1_ack} === 2'b11) begin
                    n_fail++;
                    $display("FAIL b2b_double_ack: got 11 want one-hot");
                end
                n_cmp++;
                if (got !== int'(exp_w)) begin
                    n_fail++;
                    $display("FAIL b2b_order: got m%0d want m%0d", got, exp_w);
                end
                n_cmp++;
                if (grant_id !== exp_w) begin
                    n_fail++;
                    $display("FAIL b2b_grant_id: got %b want %b", grant_id, exp_w);
                end
                ref_ptr = ~exp_w;
                i = idx[got];
                if (pw[got][i]) begin
                    ref_mem[pa[got][i][7:0]] = pd[got][i];
                end else begin
                    ref_rd[got] = ref_mem[pa[got][i][7:0]];
                    n_cmp++;
                    if (rd_of(got) !== ref_rd[got]) begin
                        n_fail++;
                        $display("FAIL b2b_rdata: got %h want %h",
                                 rd_of(got), ref_rd[got]);
                    end
                end
                rem[got]--;
                idx[got]++;
                if (rem[got] > 0) begin
                    we[got] = pw[got][idx[got]];
                    addr[got] = pa[got][idx[got]];
                    wdata[got] = pd[got][idx[got]];
                end else begin
                    req[got] = 1'b0;
                end
                done = (rem[0] == 0 && rem[1] == 0);
            end
        end
        req = 2'b00;
        n_cmp++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_timeout: got left %0d/%0d want 0/0", rem[0], rem[1]);
        end
        tick();
    endtask

    task automatic test_write_read();
        int lat, wrc, accc, bc;
        logic [31:0] wd;
        run_single(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, lat, wrc, accc, bc, wd);
        n_cmp++;
        if (lat !== 2) begin
            n_fail++; $display("FAIL wr_latency: got %0d want 2", lat);
        end
        n_cmp++;
        if ({wrc, accc} !== {32'sd1, 32'sd1}) begin
            n_fail++; $display("FAIL wr_strobe: got %0d/%0d want 1/1", wrc, accc);
        end
        n_cmp++;
        if (wd !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL wr_data: got %h want deadbeef", wd);
        end
        n_cmp++;
        if (m0_rdata !== ref_rd[0]) begin
            n_fail++; $display("FAIL wr_rdata_hold: got %h want %h", m0_rdata, ref_rd[0]);
        end
        run_single(0, 1'b0, 32'h10, 32'h0, 1'b0, lat, wrc, accc, bc, wd);
        n_cmp++;
        if (lat !== LAT + 2) begin
            n_fail++; $display("FAIL rd_latency: got %0d want %0d", lat, LAT + 2);
        end
        n_cmp++;
        if ({wrc, accc} !== {32'sd0, 32'(LAT + 1)}) begin
            n_fail++; $display("FAIL rd_access: got %0d/%0d want 0/%0d", wrc, accc, LAT + 1);
        end
        n_cmp++;
        if (m0_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL rd_data: got %h want deadbeef", m0_rdata);
        end
    endtask

    task automatic test_latency();
        int lat, wrc, accc, bc;
        logic [31:0] wd;
        run_single(1, 1'b1, 32'h20, 32'h37, 1'b0, lat, wrc, accc, bc, wd);
        run_single(1, 1'b0, 32'h20, 32'h0, 1'b0, lat, wrc, accc, bc, wd);
        n_cmp++;
        if (lat !== LAT + 2) begin
            n_fail++; $display("FAIL lat_ack: got %0d want %0d", lat, LAT + 2);
        end
        n_cmp++;
        if (m1_rdata !== 32'd55) begin
            n_fail++; $display("FAIL lat_rdata: got %0d want 55", m1_rdata);
        end
        n_cmp++;
        if (bc !== LAT + 2 || busy !== 1'b0) begin
            n_fail++; $display("FAIL lat_busy: got %0d/%b want %0d/0", bc, busy, LAT + 2);
        end
        n_cmp++;
        if (grant_id !== 1'b1) begin
            n_fail++; $display("FAIL lat_grant_id: got %b want 1", grant_id);
        end
        n_cmp++;
        if (m0_rdata !== ref_rd[0]) begin
            n_fail++; $display("FAIL lat_other_rdata: got %h want %h", m0_rdata, ref_rd[0]);
        end
    endtask

    task automatic test_payload();
        int lat, wrc, accc, bc;
        logic [31:0] wd;
        run_single(0, 1'b1, 32'h4, 32'h1, 1'b1, lat, wrc, accc, bc, wd);
        n_cmp++;
        if ({wrc, accc} !== {32'sd1, 32'sd1} || wd !== 32'h1) begin
            n_fail++;
            $display("FAIL pay_write: got %0d/%0d/%h want 1/1/1", wrc, accc, wd);
        end
        n_cmp++;
        if (mem[8'h04] !== 32'h1 || mem[8'h08] !== ref_mem[8'h08]) begin
            n_fail++;
            $display("FAIL pay_ram: got %h/%h want 1/%h",
                     mem[8'h04], mem[8'h08], ref_mem[8'h08]);
        end
    endtask

    task automatic test_random();
        int lat, wrc, accc, bc, m;
        logic w;
        logic [31:0] a, d, wd;
        for (int n = 0; n < 16; n++) begin
            m = $urandom_range(0, 1);
            w = 1'($urandom_range(0, 1));
            a = 32'h40 + 32'($urandom_range(0, 15) * 4);
            d = $urandom;
            run_single(m, w, a, d, 1'($urandom_range(0, 1)), lat, wrc, accc, bc, wd);
            n_cmp++;
            if (lat !== (w ? 2 : LAT + 2)) begin
                n_fail++; $display("FAIL rnd_latency: got %0d want %0d", lat, w ? 2 : LAT + 2);
            end
            n_cmp++;
            if (wrc !== (w ? 1 : 0) || accc !== (w ? 1 : LAT + 1)) begin
                n_fail++; $display("FAIL rnd_access: got %0d/%0d", wrc, accc);
            end
            if (w) begin
                n_cmp++;
                if (wd !== d) begin
                    n_fail++; $display("FAIL rnd_wdata: got %h want %h", wd, d);
                end
            end
            n_cmp++;
            if ({m0_rdata, m1_rdata} !== {ref_rd[0], ref_rd[1]}) begin
                n_fail++;
                $display("FAIL rnd_rdata: got %h %h want %h %h",
                         m0_rdata, m1_rdata, ref_rd[0], ref_rd[1]);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int lat, wrc, accc, bc, nack;
        logic [31:0] wd, v;
        v = $urandom;
        run_single(1, 1'b1, 32'h30, v, 1'b0, lat, wrc, accc, bc, wd);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h30; wdata[0] = $urandom;
        tick();
        tick();
        reset = 1'b1;
        req[0] = 1'b0;
        tick();
        n_cmp++;
        if ({busy, grant_id, m0_ack, m1_ack, ram_wr_sig} !== 5'b0) begin
            n_fail++;
            $display("FAIL abort_status: got %b want 00000",
                     {busy, grant_id, m0_ack, m1_ack, ram_wr_sig});
        end
        n_cmp++;
        if ({ram_addr, ram_wr_data, m0_rdata, m1_rdata} !== 128'h0) begin
            n_fail++;
            $display("FAIL abort_data: got %h %h %h %h want 0",
                     ram_addr, ram_wr_data, m0_rdata, m1_rdata);
        end
        reset = 1'b0;
        ref_ptr = 1'b0;
        ref_rd = '{default: '0};
        nack = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (m0_ack || m1_ack || busy) nack++;
        end
        n_cmp++;
        if (nack !== 0) begin
            n_fail++; $display("FAIL abort_quiet: got %0d active cycles want 0", nack);
        end
        run_single(0, 1'b0, 32'h30, 32'h0, 1'b0, lat, wrc, accc, bc, wd);
        n_cmp++;
        if (lat !== LAT + 2 || m0_rdata !== v) begin
            n_fail++;
            $display("FAIL abort_recover: got %0d/%h want %0d/%h", lat, m0_rdata, LAT + 2, v);
        end
    endtask

    initial begin
        reset = 1'b1;
        req = 2'b00;
        we = 2'b00;
        addr = '0;
        wdata = '0;
        test_reset();
        test_back_to_back();
        test_write_read();
        test_latency();
        test_payload();
        test_random();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
